// File: rtl/s8x305_fetch_ctrl.sv
// S8x305 program-memory fetch controller: services core instruction fetches,
// stalls the core through instr_ready, and grants idle memory slots to a host port.
module s8x305_fetch_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        x1,
    input  logic        reset,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_mclk,
    output logic [15:0] instr_out,
    output logic        instr_ready,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [12:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    output logic        host_ack,
    input  logic        host_halt,
    output logic        mem_en,
    output logic        mem_we,
    output logic [12:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        FETCH,
        RUN,
        HOST
    } state_t;

    // cnt is 1 during the mem_en cycle; read data is sampled when it reaches CAP_CNT
    localparam logic [4:0] CAP_CNT = 5'(MEM_LAT + 1);

    state_t      state;
    logic [4:0]  cnt;
    logic        fetch_valid;
    logic        host_is_write;

    // The core keeps executing during host slots; only a fetch stalls it.
    assign instr_ready = (state != FETCH) && !host_halt && (!cpu_mclk || fetch_valid);

    always_ff @(posedge x1 or negedge reset) begin
        if (!reset) begin
            state         <= FETCH;
            cnt           <= '0;
            fetch_valid   <= 1'b0;
            host_is_write <= 1'b0;
            instr_out     <= '0;
            host_rdata    <= '0;
            host_ack      <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            host_ack <= 1'b0;

            // The core has left cycle 3, so the held word has been consumed.
            if (instr_ready && !cpu_mclk) begin
                fetch_valid <= 1'b0;
            end

            case (state)
                FETCH: begin
                    if (cnt == '0) begin
                        mem_en   <= 1'b1;
                        mem_addr <= cpu_addr;
                        cnt      <= 5'd1;
                    end else if (cnt == CAP_CNT) begin
                        instr_out   <= mem_rdata;
                        fetch_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= RUN;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                RUN: begin
                    if (cpu_mclk && !fetch_valid) begin
                        mem_en   <= 1'b1;
                        mem_addr <= cpu_addr;
                        cnt      <= 5'd1;
                        state    <= FETCH;
                    end else if (host_req) begin
                        mem_en        <= 1'b1;
                        mem_we        <= host_we;
                        mem_addr      <= host_addr;
                        mem_wdata     <= host_wdata;
                        host_is_write <= host_we;
                        cnt           <= 5'd1;
                        state         <= HOST;
                        // Overwriting the word the core is about to execute forces a refetch.
                        if (host_we && (host_addr == cpu_addr)) begin
                            fetch_valid <= 1'b0;
                        end
                    end
                end

                HOST: begin
                    if (host_is_write) begin
                        host_ack <= 1'b1;
                        cnt      <= '0;
                        state    <= RUN;
                    end else if (cnt == CAP_CNT) begin
                        host_rdata <= mem_rdata;
                        host_ack   <= 1'b1;
                        cnt        <= '0;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s8x305_fetch_ctrl.sv
// Directed bench for s8x305_fetch_ctrl with a latency-accurate memory model
// and a host-read scoreboard checked on every host_ack.
module tb_s8x305_fetch_ctrl;

    localparam int MEM_LAT = 2;

    logic        x1 = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic        cpu_mclk = 1'b1;
    logic [15:0] instr_out;
    logic        instr_ready;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [12:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic        host_halt = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    s8x305_fetch_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .x1(x1), .reset(reset), .cpu_addr(cpu_addr), .cpu_mclk(cpu_mclk),
        .instr_out(instr_out), .instr_ready(instr_ready),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .host_halt(host_halt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 x1 = ~x1;

    // Program memory: read data appears MEM_LAT cycles after the mem_en cycle.
    logic [15:0] mem [0:8191] = '{0: 16'hC105, 1: 16'hE000, 2: 16'h5A5A,
                                  16: 16'hABCD, 17: 16'h0F0F, default: 16'h0000};
    logic [15:0] pipe [MEM_LAT];

    always @(posedge x1) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe[0] <= mem_en ? mem[mem_addr] : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge x1);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_instr_out"},   32'(instr_out),   32'h0);
        check({tag, "_instr_ready"}, 32'(instr_ready), 32'h0);
        check({tag, "_host_rdata"},  32'(host_rdata),  32'h0);
        check({tag, "_host_ack"},    32'(host_ack),    32'h0);
        check({tag, "_mem_en"},      32'(mem_en),      32'h0);
        check({tag, "_mem_we"},      32'(mem_we),      32'h0);
        check({tag, "_mem_addr"},    32'(mem_addr),    32'h0);
        check({tag, "_mem_wdata"},   32'(mem_wdata),   32'h0);
    endtask

    // Every host_ack must match a queued request; the head holds the expected host_rdata.
    always @(negedge x1) begin
        if (host_ack) begin
            check("ack_pending", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) check("host_rdata", 32'(host_rdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int st;
        int fe;

        repeat (2) @(posedge x1);
        #1;
        check_all_zero("rst");

        // 1: power-up fetch of address 0
        reset = 1'b1;
        check("t1_cycle0_mem_en", 32'(mem_en), 32'h0);
        tick(1);
        check("t1_mem_en", 32'(mem_en), 32'h1);
        check("t1_mem_addr", 32'(mem_addr), 32'h0);
        check("t1_mem_we", 32'(mem_we), 32'h0);
        check("t1_ready_c1", 32'(instr_ready), 32'h0);
        tick(2);
        check("t1_ready_c3", 32'(instr_ready), 32'h0);
        tick(1);
        check("t1_ready_c4", 32'(instr_ready), 32'h1);
        check("t1_instr", 32'(instr_out), 32'hC105);

        // 2: next fetch from address 1 stalls the core MEM_LAT+2 cycles
        cpu_mclk = 1'b0;
        tick(3);
        cpu_mclk = 1'b1;
        cpu_addr = 13'h0001;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin n++; tick(1); end
        check("t2_stall", 32'(n), 32'(MEM_LAT + 2));
        check("t2_instr", 32'(instr_out), 32'hE000);

        // 3: host read while the core runs in cycle 1
        cpu_mclk = 1'b0;
        tick(1);
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010;
        exp_q.push_back(16'hABCD);
        n = 0;
        while (!mem_en && n < 10) begin n++; tick(1); end
        check("t3_grant", 32'(mem_en), 32'h1);
        check("t3_grant_addr", 32'(mem_addr), 32'h0010);
        st = instr_ready ? 0 : 1;
        n = 0;
        while (!host_ack && n < 10) begin
            n++; tick(1);
            if (!instr_ready) st++;
        end
        check("t3_ack_lat", 32'(n), 32'(MEM_LAT + 1));
        check("t3_core_stall", 32'(st), 32'h0);
        host_req = 1'b0;

        // 4: fetch need and host request together: fetch goes first
        tick(1);
        cpu_mclk = 1'b1; cpu_addr = 13'h0002;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0011;
        exp_q.push_back(16'h0F0F);
        tick(1);
        check("t4_fetch_first", 32'(mem_en), 32'h1);
        check("t4_fetch_addr", 32'(mem_addr), 32'h0002);
        n = 0;
        do begin tick(1); n++; end while (!mem_en && n < 12);
        check("t4_host_gap", 32'(n), 32'(MEM_LAT + 2));
        check("t4_host_addr", 32'(mem_addr), 32'h0011);
        check("t4_instr", 32'(instr_out), 32'h5A5A);
        n = 0;
        while (!host_ack && n < 10) begin n++; tick(1); end
        check("t4_ack_lat", 32'(n), 32'(MEM_LAT + 1));
        host_req = 1'b0;

        // 5: halted core, host overwrites the current instruction word
        host_halt = 1'b1;
        #1;
        check("t5_halt_ready", 32'(instr_ready), 32'h0);
        tick(1);
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0002; host_wdata = 16'h1234;
        exp_q.push_back(16'h0F0F);
        n = 0;
        while (!host_ack && n < 10) begin n++; tick(1); end
        check("t5_wr_ack_lat", 32'(n), 32'h2);
        host_req = 1'b0; host_we = 1'b0;
        fe = 0; st = 0;
        repeat (8) begin
            tick(1);
            if (mem_en && !mem_we && mem_addr == 13'h0002) fe++;
            if (instr_ready) st++;
        end
        check("t5_refetch", 32'(fe), 32'h1);
        check("t5_halt_hold", 32'(st), 32'h0);
        host_halt = 1'b0;
        #1;
        check("t5_resume", 32'(instr_ready), 32'h1);
        check("t5_instr", 32'(instr_out), 32'h1234);

        // 6: reset in the middle of a host read
        tick(1);
        cpu_mclk = 1'b0;
        tick(1);
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010;
        n = 0;
        while (!mem_en && n < 10) begin n++; tick(1); end
        check("t6_grant", 32'(mem_en), 32'h1);
        tick(1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("t6_rst");
        host_req = 1'b0; cpu_addr = 13'h0001; cpu_mclk = 1'b1;
        tick(3);
        check("t6_no_ack", 32'(host_ack), 32'h0);
        check("t6_idle", 32'(mem_en), 32'h0);
        reset = 1'b1;
        tick(1);
        check("t6_refetch", 32'(mem_en), 32'h1);
        check("t6_refetch_addr", 32'(mem_addr), 32'h0001);
        n = 0;
        while (!instr_ready && n < 20) begin n++; tick(1); end
        check("t6_ready", 32'(instr_ready), 32'h1);
        check("t6_instr", 32'(instr_out), 32'hE000);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
